jtroadf_snd_latch: RTL

//  Sound-side receiver for the main-to-sound command channel. Captures bytes the main
//  CPU writes (main_dout qualified by m2s_data) into a small FIFO. Turns m2s_irq rising

---
 rtl/jtkicker_snd_pkg.sv | 13 +
 rtl/jtkicker_edge.sv | 28 ++
 rtl/jtroadf_snd_latch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/jtkicker_snd_pkg.sv
// Shared definitions for the main-to-sound command latch.
//   irq_st_e  : interrupt hand-shake states (ST_IDLE=0, ST_PEND=1)
//   DEF_DEPTH : default number of FIFO entries
package jtkicker_snd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } irq_st_e;

  localparam int DEF_DEPTH = 2;

endpackage

// File: rtl/jtkicker_edge.sv
// Registered rising-edge detector with an optional clock-enable qualifier.
//   clk  : system clock
//   rst  : synchronous active-high reset; reloads the current input level
//   cen  : qualifier, the input is only looked at while cen is high
//   din  : level to watch
//   rise : high for the cycle in which din is first seen high (combinational)
module jtkicker_edge (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic din,
  output logic rise
);

  logic prev;

  // Loading the live level during reset means an input held high across
  // reset release is treated as already seen and does not fire.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)      prev <= din;
    else if (cen) prev <= din;
  end

  assign rise = cen & din & ~prev;

endmodule

// File: rtl/jtroadf_snd_latch.sv
// Sound-side receiver of the main-to-sound command channel (clk24 domain).
// Bytes written by the main CPU are queued in a small FIFO read by the
// sound CPU; m2s_irq rising edges become a held active-low Z80 interrupt
// released by the interrupt acknowledge.
//   clk       : 24MHz system clock
//   rst       : synchronous active-high reset
//   main_dout : main CPU data bus
//   m2s_data  : latch chip-select level, one push per rising edge
//   m2s_irq   : interrupt request level, rising edge = request
//   snd_cen   : sound CPU clock enable, qualifies snd_rd and snd_iack
//   snd_rd    : sound CPU latch read strobe (level), one pop per rising edge
//   snd_iack  : sound CPU interrupt acknowledge (level)
//   snd_dout  : byte at FIFO head, last popped byte while empty
//   snd_irqn  : active-low interrupt to the sound CPU
//   level     : bytes queued, 0..DEPTH
//   ovf       : sticky, a write arrived while full and nothing was freed
module jtroadf_snd_latch
  import jtkicker_snd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    main_dout,
  input  logic          m2s_data,
  input  logic          m2s_irq,
  input  logic          snd_cen,
  input  logic          snd_rd,
  input  logic          snd_iack,
  output logic [7:0]    snd_dout,
  output logic          snd_irqn,
  output logic [AW:0]   level,
  output logic          ovf
);

  // Pointers carry one extra MSB so full (wr-rd == DEPTH) differs from empty.
  localparam int PW = AW + 1;
  // Index width kept at least one bit so DEPTH=1 still has a legal select.
  localparam int IW = (AW > 0) ? AW : 1;
  localparam int MW = 1 << IW;

  logic wr_rise, irq_rise, rd_rise;

  jtkicker_edge u_wr_edge (
    .clk  (clk),
    .rst  (rst),
    .cen  (1'b1),
    .din  (m2s_data),
    .rise (wr_rise)
  );

  jtkicker_edge u_irq_edge (
    .clk  (clk),
    .rst  (rst),
    .cen  (1'b1),
    .din  (m2s_irq),
    .rise (irq_rise)
  );

  jtkicker_edge u_rd_edge (
    .clk  (clk),
    .rst  (rst),
    .cen  (snd_cen),
    .din  (snd_rd),
    .rise (rd_rise)
  );

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [IW-1:0] wr_idx, rd_idx, rd_nxt_idx;
  logic [7:0]    mem [MW];
  logic [7:0]    head_nxt;
  logic          full, empty, pop_ok, push_ok, wr_blocked, overwrite;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot in the same cycle, so a write while full still lands
  // when it coincides with a read; only an unmatched write is blocked.
  assign pop_ok     = rd_rise & ~empty;
  assign push_ok    = wr_rise & (~full | pop_ok);
  assign wr_blocked = wr_rise & full & ~pop_ok;
  // A single-entry FIFO behaves as a plain latch: blocked writes replace it.
  assign overwrite  = wr_blocked & (DEPTH == 1);

  assign wr_nxt = wr_ptr + PW'(push_ok);
  assign rd_nxt = rd_ptr + PW'(pop_ok);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_idx     = '0;
    rd_idx     = '0;
    rd_nxt_idx = '0;
    if (DEPTH > 1) begin
      wr_idx     = wr_ptr[IW-1:0];
      rd_idx     = rd_ptr[IW-1:0];
      rd_nxt_idx = rd_nxt[IW-1:0];
    end
  end

  // Head after this cycle: a byte being written this cycle bypasses memory
  // when it becomes the new head.
  always_comb begin
    head_nxt = mem[rd_nxt_idx];
    if ((push_ok && wr_idx == rd_nxt_idx) || overwrite) head_nxt = main_dout;
  end

  // NOTE: the storage array has no reset; pointers define which entries are
  // valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok)        mem[wr_idx] <= main_dout;
      else if (overwrite) mem[rd_idx] <= main_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      snd_dout <= 8'h00;
      ovf      <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_blocked) ovf <= 1'b1;
      // When the FIFO drains, the output keeps the byte just popped.
      if (wr_nxt != rd_nxt) snd_dout <= head_nxt;
    end
  end

  irq_st_e irq_st;

  // A new request beats an acknowledge in the same cycle, so a request
  // arriving during the ack is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_st   <= ST_IDLE;
      snd_irqn <= 1'b1;
    end else begin
      case (irq_st)
        ST_IDLE: begin
          if (irq_rise) begin
            irq_st   <= ST_PEND;
            snd_irqn <= 1'b0;
          end
        end
        ST_PEND: begin
          if (snd_iack && snd_cen && !irq_rise) begin
            irq_st   <= ST_IDLE;
            snd_irqn <= 1'b1;
          end
        end
        default: begin
          irq_st   <= ST_IDLE;
          snd_irqn <= 1'b1;
        end
      endcase
    end
  end

endmodule
